// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU sequencer: FSM states,
// opcode classes, opcode and condition encodings, and the condition evaluator.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WRITE,
        HALT
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_JMP,
        CLS_HALT
    } op_class_e;

    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_Z  = 2'b01;
    localparam logic [1:0] COND_C  = 2'b10;
    localparam logic [1:0] COND_NZ = 2'b11;

    function automatic logic cond_pass(input logic [1:0] cond, input logic z, input logic c);
        logic pass;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_Z:  pass = z;
            COND_C:  pass = c;
            default: pass = !z;
        endcase
        return pass;
    endfunction

    function automatic op_class_e op_class(input logic [3:0] opcode);
        op_class_e cls;
        case (opcode)
            OP_JMP:  cls = CLS_JMP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ALU;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_seq_wdog.sv
// Handshake timeout counter: counts cycles while run is high, restarts on clear,
// and flags expire on the WDOG_CYCLES-th consecutive waiting cycle.
module cpu_seq_wdog #(
    parameter int WDOG_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the 16-bit CPU; owns pc, ir and the retired count.
// Optional handshake watchdog compiled in with `define CPU_SEQ_WDOG_EN.
module cpu_sequencer #(
    parameter int PC_W        = 8,
    parameter int WDOG_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    input  logic [1:0]      dec_cond,
    input  logic [3:0]      dec_opcode,
    input  logic [7:0]      dec_en,
    input  logic            flag_z,
    input  logic            flag_c,
    output logic            alu_start,
    input  logic            alu_done,
    output logic [7:0]      reg_wr_en,
    output logic            flags_we,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired,
    output logic            halted,
    output logic            fault
);
    import cpu_pkg::*;

    state_e          state_q, state_d;
    op_class_e       cls_q, cls_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     retired_q, retired_d;
    logic            cp_q, cp_d;
    logic            jmp_taken_q, jmp_taken_d;
    logic            imem_req_q, imem_req_d;
    logic            alu_start_q, alu_start_d;
    logic [7:0]      reg_wr_en_q, reg_wr_en_d;
    logic            flags_we_q, flags_we_d;
    logic            halted_q, halted_d;
    logic            wdog_expire;

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        cp_d        = cp_q;
        jmp_taken_d = jmp_taken_q;
        alu_start_d = 1'b0;
        reg_wr_en_d = '0;
        flags_we_d  = 1'b0;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end else if (wdog_expire) begin
                    state_d = HALT;
                end
            end
            DECODE: begin
                cp_d        = cond_pass(dec_cond, flag_z, flag_c);
                cls_d       = op_class(dec_opcode);
                jmp_taken_d = 1'b0;
                alu_start_d = (op_class(dec_opcode) == CLS_ALU);
                state_d     = EXEC;
            end
            EXEC: begin
                case (cls_q)
                    CLS_HALT: state_d = cp_q ? HALT : WRITE;
                    CLS_JMP: begin
                        if (cp_q) begin
                            pc_d        = ir_q[PC_W-1:0];
                            jmp_taken_d = 1'b1;
                        end
                        state_d = WRITE;
                    end
                    default: begin
                        // Strobes are registered here so they appear exactly in WRITE.
                        if (alu_done) begin
                            if (cp_q) begin
                                reg_wr_en_d = dec_en;
                                flags_we_d  = 1'b1;
                            end
                            state_d = WRITE;
                        end else if (wdog_expire) begin
                            state_d = HALT;
                        end
                    end
                endcase
            end
            WRITE: begin
                if (!jmp_taken_q) begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (retired_q != 16'hFFFF) begin
                    retired_d = retired_q + 16'd1;
                end
                state_d = FETCH;
            end
            default: state_d = HALT;
        endcase

        imem_req_d = (state_d == FETCH);
        halted_d   = (state_d == HALT);
    end

    // imem_req resets high because the reset state is FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            cls_q       <= CLS_ALU;
            ir_q        <= '0;
            pc_q        <= '0;
            retired_q   <= '0;
            cp_q        <= 1'b0;
            jmp_taken_q <= 1'b0;
            imem_req_q  <= 1'b1;
            alu_start_q <= 1'b0;
            reg_wr_en_q <= '0;
            flags_we_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            cp_q        <= cp_d;
            jmp_taken_q <= jmp_taken_d;
            imem_req_q  <= imem_req_d;
            alu_start_q <= alu_start_d;
            reg_wr_en_q <= reg_wr_en_d;
            flags_we_q  <= flags_we_d;
            halted_q    <= halted_d;
        end
    end

`ifdef CPU_SEQ_WDOG_EN
    logic wdog_run;
    logic fault_q, fault_d;

    assign wdog_run = ((state_q == FETCH) && !imem_ack) ||
                      ((state_q == EXEC) && (cls_q == CLS_ALU) && !alu_done);

    cpu_seq_wdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (wdog_run),
        .clear  (!wdog_run || wdog_expire),
        .expire (wdog_expire)
    );

    always_comb begin
        fault_d = fault_q | wdog_expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign wdog_expire = 1'b0;
    assign fault       = 1'b0;

    if (WDOG_CYCLES < 1) begin : g_wdog_cycles_check
        $error("WDOG_CYCLES must be at least 1");
    end
`endif

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign alu_start = alu_start_q;
    assign reg_wr_en = reg_wr_en_q;
    assign flags_we  = flags_we_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of instructions with expected
// strobes/pc/latency, a scoreboard queue, and hand sequences for reset, saturation, watchdog.
module tb_cpu_sequencer;
    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;
    logic [15:0]     ir;
    logic [1:0]      dec_cond;
    logic [3:0]      dec_opcode;
    logic [7:0]      dec_en;
    logic            flag_z;
    logic            flag_c;
    logic            alu_start;
    logic            alu_done;
    logic [7:0]      reg_wr_en;
    logic            flags_we;
    logic [PC_W-1:0] pc;
    logic [15:0]     retired;
    logic            halted;
    logic            fault;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(PC_W), .WDOG_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .dec_cond(dec_cond),
        .dec_opcode(dec_opcode), .dec_en(dec_en), .flag_z(flag_z), .flag_c(flag_c),
        .alu_start(alu_start), .alu_done(alu_done), .reg_wr_en(reg_wr_en),
        .flags_we(flags_we), .pc(pc), .retired(retired), .halted(halted), .fault(fault)
    );

    // Decoder model: cond/opcode fields and a one-hot destination from ir[2:0].
    assign dec_cond   = ir[15:14];
    assign dec_opcode = ir[13:10];
    assign dec_en     = 8'h01 << ir[2:0];

    typedef struct {
        logic [15:0] word;
        logic        z;
        logic        c;
        int          ack_lat;
        int          done_lat;
        logic [7:0]  exp_wr;
        logic        exp_fwe;
        int          exp_starts;
        logic [7:0]  exp_pc;
        logic        exp_halt;
    } vec_t;

    typedef struct {
        logic [7:0]  wr;
        logic        fwe;
        int          starts;
        int          cycles;
        logic [7:0]  pc;
        logic        halt;
        logic [15:0] retired;
        logic [15:0] word;
    } exp_t;

    vec_t       vecs[11];
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [15:0] model_retired;
    logic [7:0]  exp_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        alu_done   = 1'b0;
        flag_z     = 1'b0;
        flag_c     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        model_retired = 16'h0000;
        exp_addr      = 8'h00;
    endtask

    task automatic run_instr(input vec_t v);
        exp_t       e;
        exp_t       got;
        int         starts = 0;
        int         strobe_cycles = 0;
        int         cycles = 0;
        int         dcnt = -1;
        bit         fin = 1'b0;
        logic [7:0] wr_acc = 8'h00;
        logic       fwe_acc = 1'b0;
        logic       is_alu;

        is_alu   = (v.word[13:10] < 4'd14);
        e.wr     = v.exp_wr;
        e.fwe    = v.exp_fwe;
        e.starts = v.exp_starts;
        e.pc     = v.exp_pc;
        e.halt   = v.exp_halt;
        e.word   = v.word;
        e.cycles = v.ack_lat + 4 + (is_alu ? v.done_lat : 0) - (v.exp_halt ? 1 : 0);
        if (!v.exp_halt && model_retired != 16'hFFFF) model_retired = model_retired + 16'd1;
        e.retired = model_retired;
        exp_q.push_back(e);

        flag_z = v.z;
        flag_c = v.c;
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_addr});
        for (int i = 0; i < v.ack_lat; i++) begin
            alu_done = 1'b1;
            @(negedge clk);
            cycles++;
            check("fetch_addr_stable", {24'd0, imem_addr}, {24'd0, exp_addr});
        end
        alu_done   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = v.word;
        @(negedge clk);
        cycles++;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            if (imem_req || halted) begin
                fin = 1'b1;
            end else begin
                if (alu_start) begin
                    starts++;
                    dcnt = v.done_lat;
                end
                if (reg_wr_en != 8'h00 || flags_we) strobe_cycles++;
                wr_acc     = wr_acc | reg_wr_en;
                fwe_acc    = fwe_acc | flags_we;
                alu_done   = (dcnt == 0);
                if (dcnt >= 0) dcnt--;
                imem_ack   = 1'b1;
                imem_rdata = 16'hFFFF;
                @(negedge clk);
                cycles++;
            end
        end
        imem_ack = 1'b0;
        alu_done = 1'b0;
        if (!fin) check("instr_timeout", 32'd0, 32'd1);

        got = exp_q.pop_front();
        check("reg_wr_en", {24'd0, wr_acc}, {24'd0, got.wr});
        check("flags_we", {31'd0, fwe_acc}, {31'd0, got.fwe});
        check("strobe_cycles", strobe_cycles, {31'd0, got.fwe});
        check("alu_starts", starts, got.starts);
        check("instr_cycles", cycles, got.cycles);
        check("ir", {16'd0, ir}, {16'd0, got.word});
        check("pc", {24'd0, pc}, {24'd0, got.pc});
        check("retired", {16'd0, retired}, {16'd0, got.retired});
        check("halted", {31'd0, halted}, {31'd0, got.halt});
        check("fault", {31'd0, fault}, 32'd0);
        if (!got.halt) check("next_fetch_addr", {24'd0, imem_addr}, {24'd0, got.pc});
        exp_addr = got.pc;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        //         word     z     c     ack dn  wr     fwe   st  pc     halt
        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 0, 0,  8'h01, 1'b1, 1, 8'h01, 1'b0};
        vecs[1]  = '{16'h4005, 1'b0, 1'b0, 0, 0,  8'h00, 1'b0, 1, 8'h02, 1'b0};
        vecs[2]  = '{16'h4003, 1'b1, 1'b0, 2, 3,  8'h08, 1'b1, 1, 8'h03, 1'b0};
        vecs[3]  = '{16'h3842, 1'b0, 1'b0, 0, 0,  8'h00, 1'b0, 0, 8'h42, 1'b0};
        vecs[4]  = '{16'h8007, 1'b0, 1'b1, 1, 10, 8'h80, 1'b1, 1, 8'h43, 1'b0};
        vecs[5]  = '{16'hC001, 1'b1, 1'b0, 0, 0,  8'h00, 1'b0, 1, 8'h44, 1'b0};
        vecs[6]  = '{16'h78FE, 1'b0, 1'b0, 0, 0,  8'h00, 1'b0, 0, 8'h45, 1'b0};
        vecs[7]  = '{16'h38FF, 1'b0, 1'b0, 0, 0,  8'h00, 1'b0, 0, 8'hFF, 1'b0};
        vecs[8]  = '{16'h0002, 1'b0, 1'b0, 0, 1,  8'h04, 1'b1, 1, 8'h00, 1'b0};
        vecs[9]  = '{16'h7C00, 1'b0, 1'b0, 0, 0,  8'h00, 1'b0, 0, 8'h01, 1'b0};
        vecs[10] = '{16'hFC00, 1'b0, 1'b0, 0, 0,  8'h00, 1'b0, 0, 8'h01, 1'b1};

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_ir", {16'd0, ir}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_strobes", {22'd0, alu_start, flags_we, reg_wr_en}, 32'd0);
        check("rst_halted_fault", {30'd0, halted, fault}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Main program
        for (int i = 0; i < 11; i++) run_instr(vecs[i]);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            alu_done = 1'b1;
            @(negedge clk);
            check("halt_no_req", {31'd0, imem_req}, 32'd0);
            check("halt_stays", {31'd0, halted}, 32'd1);
            check("halt_strobes", {22'd0, alu_start, flags_we, reg_wr_en}, 32'd0);
            check("halt_pc", {24'd0, pc}, 32'd1);
        end
        imem_ack = 1'b0;
        alu_done = 1'b0;

        // Asynchronous reset mid-EXEC
        do_reset();
        run_instr(vecs[0]);
        run_instr(vecs[1]);
        imem_ack   = 1'b1;
        imem_rdata = 16'h0003;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("mid_exec_start", {31'd0, alu_start}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", {24'd0, pc}, 32'd0);
        check("async_rst_ir", {16'd0, ir}, 32'd0);
        check("async_rst_retired", {16'd0, retired}, 32'd0);
        check("async_rst_strobes", {22'd0, alu_start, flags_we, reg_wr_en}, 32'd0);
        check("async_rst_halted_fault", {30'd0, halted, fault}, 32'd0);
        check("async_rst_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Retired counter saturation
        do_reset();
        @(negedge clk);
        force dut.retired_q = 16'hFFFE;
        @(negedge clk);
        release dut.retired_q;
        check("retired_preset", {16'd0, retired}, 32'h0000FFFE);
        model_retired = 16'hFFFE;
        for (int i = 0; i < 3; i++) run_instr(vecs[i]);

`ifdef CPU_SEQ_WDOG_EN
        // Fetch watchdog expiry
        do_reset();
        repeat (15) @(negedge clk);
        check("wdog_not_yet", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check("wdog_halted", {31'd0, halted}, 32'd1);
        check("wdog_fault", {31'd0, fault}, 32'd1);
        check("wdog_no_req", {31'd0, imem_req}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
